// File: rtl/axis_s_interface_if.sv
// ---------------------------------------------------------------------------
// axis_s_interface_if
//   Bundles the signals of the read-side deserializer stage: the byte stream
//   coming out of the asynchronous FIFO and the AXI-Stream style word output.
//
//   i_from_fifo   byte popped from the FIFO, valid the cycle after r_req
//   r_empty       FIFO empty flag, synchronous to the output clock
//   r_req         FIFO pop request, one byte per high cycle
//   s_axis_tdata  assembled word, first popped byte in bits [7:0]
//   s_axis_valid  s_axis_tdata holds a complete word
//   s_axis_ready  downstream accepts the word when high together with valid
//
//   slave  : view of the deserializer itself
//   master : view of the environment (FIFO + downstream consumer)
// ---------------------------------------------------------------------------
interface axis_s_interface_if #(
  parameter int LOGIC_SIZE = 32
);
  logic [7:0]            i_from_fifo;
  logic                  r_empty;
  logic                  r_req;
  logic [LOGIC_SIZE-1:0] s_axis_tdata;
  logic                  s_axis_valid;
  logic                  s_axis_ready;

  modport slave (
    input  i_from_fifo,
    input  r_empty,
    input  s_axis_ready,
    output r_req,
    output s_axis_tdata,
    output s_axis_valid
  );

  modport master (
    output i_from_fifo,
    output r_empty,
    output s_axis_ready,
    input  r_req,
    input  s_axis_tdata,
    input  s_axis_valid
  );
endinterface

// File: rtl/axis_s_interface.sv
// ---------------------------------------------------------------------------
// axis_s_interface
//   Read-side stage of the AXIS serializer/deserializer link. Pops bytes from
//   the asynchronous byte FIFO and reassembles them, LSB byte first, into
//   LOGIC_SIZE-bit words presented on a valid/ready output.
//
//   Ports
//     s_axis_aclk   output-domain clock (only clock of the block)
//     s_axis_reset  asynchronous, active-high reset; clears all state
//     s_if          axis_s_interface_if.slave bundle: i_from_fifo, r_empty,
//                   r_req, s_axis_tdata, s_axis_valid, s_axis_ready
//
//   Storage: one word being assembled (asm) plus one word in the output
//   holding register (out). When both are occupied no further pops happen.
// ---------------------------------------------------------------------------
module axis_s_interface #(
  parameter int LOGIC_SIZE = 32
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_reset,
  axis_s_interface_if.slave s_if
);

  localparam int NBYTES = LOGIC_SIZE / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W:0]   NB_WIDE  = (CNT_W + 1)'(NBYTES);

  logic [LOGIC_SIZE-1:0] asm_q,      asm_d;
  logic [LOGIC_SIZE-1:0] out_q,      out_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                  rd_pend_q,  rd_pend_d;
  logic                  asm_full_q, asm_full_d;
  logic                  valid_q,    valid_d;

  logic                  slot_free;
  logic                  word_done;
  logic                  load;
  logic                  r_req_c;
  logic [CNT_W:0]        in_flight;
  logic [CNT_W+2:0]      lane_base;

  always_comb begin
    slot_free  = !valid_q || s_if.s_axis_ready;

    // Bytes already captured plus the one still in flight must leave room
    // for another; this forces one idle r_req cycle while the last byte lands.
    in_flight  = {1'b0, byte_cnt_q} + {{CNT_W{1'b0}}, rd_pend_q};
    r_req_c    = !s_axis_reset && !s_if.r_empty && !asm_full_q &&
                 (in_flight < NB_WIDE);

    lane_base  = {byte_cnt_q, 3'b000};
    asm_d      = asm_q;
    if (rd_pend_q) begin
      asm_d[lane_base +: 8] = s_if.i_from_fifo;
    end

    word_done  = rd_pend_q && (byte_cnt_q == LAST_IDX);
    // Either a freshly completed word or a blocked one moves to the output.
    // A blocked word never has a byte in flight, so asm_d equals asm_q then.
    load       = (word_done || asm_full_q) && slot_free;

    out_d      = load ? asm_d : out_q;

    valid_d    = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && s_if.s_axis_ready) begin
      valid_d = 1'b0;
    end

    asm_full_d = asm_full_q;
    if (word_done && !slot_free) begin
      asm_full_d = 1'b1;
    end else if (asm_full_q && slot_free) begin
      asm_full_d = 1'b0;
    end

    byte_cnt_d = byte_cnt_q;
    if (rd_pend_q && (byte_cnt_q != LAST_IDX)) begin
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end else if (load) begin
      byte_cnt_d = '0;
    end

    rd_pend_d  = r_req_c;
  end

  // Register stage: everything, including the data words, is cleared by reset
  // so no stale bytes survive into the next word.
  always_ff @(posedge s_axis_aclk or posedge s_axis_reset) begin
    if (s_axis_reset) begin
      asm_q      <= '0;
      out_q      <= '0;
      byte_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      asm_full_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      out_q      <= out_d;
      byte_cnt_q <= byte_cnt_d;
      rd_pend_q  <= rd_pend_d;
      asm_full_q <= asm_full_d;
      valid_q    <= valid_d;
    end
  end

  assign s_if.r_req        = r_req_c;
  assign s_if.s_axis_tdata = out_q;
  assign s_if.s_axis_valid = valid_q;

endmodule

// File: doc/axis_s_interface.md
# axis_s_interface

Read-side stage of the AXIS serializer/deserializer link. Pops bytes from the asynchronous byte FIFO in the output clock domain and reassembles them, LSB byte first, into LOGIC_SIZE-bit words. Presents each completed word on an AXI-Stream style valid/ready output to the downstream consumer. It is the mirror of the write-side serializer, which pushes byte lane 0 first.

## Interface
- LOGIC_SIZE, 32, output word width in bits; multiple of 8, ≥16; NBYTES = LOGIC_SIZE/8.
- s_axis_aclk  in  1  output-domain clock; the only clock in the block.
- s_axis_reset  in  1  reset, asynchronous and active-high; clears all state immediately.
- i_from_fifo  in  8  byte read from the async FIFO; valid the cycle after an r_req cycle.
- r_empty  in  1  async FIFO empty flag, synchronous to s_axis_aclk.
- r_req  out  1  FIFO pop request; one byte per cycle high.
- s_axis_tdata  out  LOGIC_SIZE  assembled word; byte k = k-th byte popped for that word.
- s_axis_valid  out  1  s_axis_tdata holds a complete word.
- s_axis_ready  in  1  downstream accepts the word when high with s_axis_valid.

## Operation
- State:
  - asm_reg (LOGIC_SIZE), the assembly register.
  - byte_cnt (0..NBYTES-1, $clog2(NBYTES) bits), the bytes captured into asm_reg.
  - rd_pend (1 bit), a byte in flight from the FIFO.
  - asm_full (1 bit), a completed word blocked by the output.
  - out_reg/s_axis_valid, the one-entry output holding register.
- r_req = !s_axis_reset && !r_empty && !asm_full && (byte_cnt + rd_pend < NBYTES). It is combinational from registered state plus r_empty. Never assert it while r_empty=1.
- rd_pend <= r_req each cycle.
- Capture, on a cycle with rd_pend=1: i_from_fifo is written to asm_reg[byte_cnt*8 +: 8].
  - If byte_cnt < NBYTES-1: byte_cnt increments.
  - If byte_cnt == NBYTES-1, the word is complete:
    - If the output slot is free this cycle (s_axis_valid=0, or s_axis_valid && s_axis_ready), the full word (new byte merged) loads out_reg, s_axis_valid <= 1, and byte_cnt wraps to 0.
    - Otherwise, asm_full <= 1 and byte_cnt stays at NBYTES-1.
- Blocked word: while asm_full=1, the word moves to out_reg on the first cycle the output slot is free. At that edge asm_full <= 0 and byte_cnt <= 0. r_req may rise in the following cycle.
- Output handshake: on s_axis_valid && s_axis_ready with no new word loading that cycle, s_axis_valid <= 0. s_axis_tdata and s_axis_valid hold stable while valid=1 and ready=0.
- Simultaneous handshake and word load in the same cycle: out_reg takes the new word and s_axis_valid stays 1.
- Byte order: the first popped byte goes to bits [7:0] and the last to [LOGIC_SIZE-1:LOGIC_SIZE-8].
- No bytes are dropped or duplicated outside reset. There is no partial-word flush; an incomplete word waits for its remaining bytes indefinitely.
- Reset mid-operation:
  - asm_reg, byte_cnt, rd_pend, asm_full and out_reg are cleared.
  - A byte already popped (rd_pend=1) is discarded; its FIFO slot is consumed and lost by design.
  - The partial word is discarded.

## Timing
- Reset values: r_req=0, s_axis_valid=0, s_axis_tdata=0. Internal state is all zero.
- Read latency: r_req high in cycle N means the byte is on i_from_fifo and captured at the end of cycle N+1.
- Word latency: the first r_req of a word in cycle N gives s_axis_valid=1 from cycle N+NBYTES+1, provided bytes are available every cycle and the output slot is free.
- Sustained throughput with FIFO never empty and s_axis_ready=1: one word per NBYTES+1 cycles. This is r_req high NBYTES cycles, then low one cycle while the last byte lands.
- r_empty is sampled combinationally each cycle; an empty gap simply delays r_req, with no other state change.
- Backpressure: at most one word in out_reg plus one complete word in asm_reg. No further FIFO pops occur until out_reg drains.

## Test plan
- Reset release, FIFO empty: r_req, s_axis_valid and s_axis_tdata stay 0 for 20 cycles.
- FIFO holds bytes 0x11,0x22,0x33,0x44 and s_axis_ready=1:
  - r_req is high for exactly 4 cycles.
  - s_axis_tdata=0x44332211 with valid for exactly 1 cycle.
  - Valid appears 5 cycles after the first r_req.
- Streaming 0x00..0x0F with ready=1: output is 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, spaced 5 cycles apart.
- Backpressure: ready=0 while 8 bytes 0xA0..0xA7 are available.
  - Word 0xA3A2A1A0 holds stable and asm_full=1 after the 8th byte.
  - r_req stays 0 with the FIFO non-empty.
  - Raising ready for 2 cycles delivers 0xA3A2A1A0 then 0xA7A6A5A4, with no loss.
- Bursty FIFO (r_empty toggles every other cycle), bytes 0x01..0x04: r_req never asserts while r_empty=1, and the output is 0x04030201.
- Reset asserted asynchronously after 2 of 4 bytes: outputs clear without waiting for a clock edge. After release, bytes 0x55,0x66,0x77,0x88 yield 0x88776655 with no stale bytes.
